dp_ram_arbiter: RTL

//  Round-robin arbiter sharing one dp_ram port among NUM_REQ requesters.

---
 rtl/dp_ram_arbiter_if.sv | 38 +++
 rtl/dp_ram_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/dp_ram_arbiter_if.sv
// Requester command/response bus and dp_ram port bundle for dp_ram_arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters and the RAM.
interface dp_ram_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RAM_DEPTH  = 512,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH);
    localparam int unsigned WREN_WIDTH = (DATA_WIDTH + 7) / 8;

    logic [NUM_REQ-1:0]            reqValidIn;
    logic [NUM_REQ-1:0]            reqWrIn;
    logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddrIn;
    logic [NUM_REQ*WREN_WIDTH-1:0] reqWrEnIn;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqWrDataIn;
    logic [NUM_REQ-1:0]            reqReadyOut;
    logic [DATA_WIDTH-1:0]         rspDataOut;
    logic [NUM_REQ-1:0]            rspAckOut;
    logic [ADDR_WIDTH-1:0]         ramAddrOut;
    logic [WREN_WIDTH-1:0]         ramWrEnOut;
    logic [DATA_WIDTH-1:0]         ramWrDataOut;
    logic                          ramRdEnOut;
    logic [DATA_WIDTH-1:0]         ramRdDataIn;
    logic                          ramRdAckIn;
    logic                          errOut;

    modport slave (
        input  reqValidIn, reqWrIn, reqAddrIn, reqWrEnIn, reqWrDataIn, ramRdDataIn, ramRdAckIn,
        output reqReadyOut, rspDataOut, rspAckOut, ramAddrOut, ramWrEnOut, ramWrDataOut,
               ramRdEnOut, errOut
    );

    modport master (
        output reqValidIn, reqWrIn, reqAddrIn, reqWrEnIn, reqWrDataIn, ramRdDataIn, ramRdAckIn,
        input  reqReadyOut, rspDataOut, rspAckOut, ramAddrOut, ramWrEnOut, ramWrDataOut,
               ramRdEnOut, errOut
    );
endinterface

// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter sharing one dp_ram port among NUM_REQ requesters.
// Commands are issued registered, and read data returns in order through a requester-id tag pipe.
module dp_ram_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RAM_DEPTH  = 512,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic            clkIn,
    input logic            rstIn,
    dp_ram_arbiter_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH);
    localparam int unsigned WREN_WIDTH = (DATA_WIDTH + 7) / 8;
    localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ);

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } tag_t;

    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   grantId;
    logic [ID_WIDTH-1:0]   issueId;
    logic                  grantValid;
    logic [NUM_REQ-1:0]    grant;
    int unsigned           cand;
    logic [ADDR_WIDTH-1:0] addrArr [NUM_REQ];
    logic [WREN_WIDTH-1:0] wrEnArr [NUM_REQ];
    logic [DATA_WIDTH-1:0] dataArr [NUM_REQ];
    tag_t                  tagPipe [RD_LATENCY];
    tag_t                  head;

    for (genvar g = 0; g < NUM_REQ; g++) begin : gSplit
        assign addrArr[g] = bus.reqAddrIn[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wrEnArr[g] = bus.reqWrEnIn[g*WREN_WIDTH +: WREN_WIDTH];
        assign dataArr[g] = bus.reqWrDataIn[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or above ptr, wrapping around.
    always_comb begin
        grantValid = 1'b0;
        grantId    = '0;
        cand       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!grantValid && bus.reqValidIn[ID_WIDTH'(cand)]) begin
                grantValid = 1'b1;
                grantId    = ID_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grantValid && !rstIn) grant[grantId] = 1'b1;
    end

    assign bus.reqReadyOut = grant;
    assign head            = tagPipe[RD_LATENCY-1];

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            ptr              <= '0;
            issueId          <= '0;
            bus.ramAddrOut   <= '0;
            bus.ramWrEnOut   <= '0;
            bus.ramWrDataOut <= '0;
            bus.ramRdEnOut   <= 1'b0;
        end else begin
            bus.ramWrEnOut <= '0;
            bus.ramRdEnOut <= 1'b0;
            if (grantValid) begin
                ptr              <= (grantId == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
                issueId          <= grantId;
                bus.ramAddrOut   <= addrArr[grantId];
                bus.ramWrDataOut <= dataArr[grantId];
                if (bus.reqWrIn[grantId]) bus.ramWrEnOut <= wrEnArr[grantId];
                else                      bus.ramRdEnOut <= 1'b1;
            end
        end
    end

    // Tags enter alongside ramRdEnOut so the head lines up with the RAM's ack.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            for (int unsigned k = 0; k < RD_LATENCY; k++) tagPipe[k] <= '0;
        end else begin
            tagPipe[0] <= '{valid: bus.ramRdEnOut, id: issueId};
            for (int unsigned k = 1; k < RD_LATENCY; k++) tagPipe[k] <= tagPipe[k-1];
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            bus.rspAckOut  <= '0;
            bus.rspDataOut <= '0;
            bus.errOut     <= 1'b0;
        end else begin
            bus.rspAckOut <= '0;
            if (head.valid && bus.ramRdAckIn) begin
                bus.rspAckOut[head.id] <= 1'b1;
                bus.rspDataOut         <= bus.ramRdDataIn;
            end else if (head.valid || bus.ramRdAckIn) begin
                bus.errOut <= 1'b1;
            end
        end
    end
endmodule
